regfile_scoreboard: RTL

Parametrised successor to the 16x16 two-read/one-write CPU register file. It adds configurable width, depth and read-port count. It also adds a per-register busy scoreboard, so decode can detect RAW hazards against in-flight writebacks, and optional same-cycle write-to-read bypass. It sits between decode (read/issue) and writeback (write) in the pipeline.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_read_port.sv | 50 +++++
 rtl/regfile_scoreboard.sv | 88 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register file with busy scoreboard.
//   RF_WIDTH_DEF / RF_DEPTH_DEF / RF_NUM_RD_DEF : default parameter values
//   RF_ZERO_REG                                 : index of the hardwired-zero register
// Optional feature macro used by the design: RF_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  localparam int RF_WIDTH_DEF  = 16;
  localparam int RF_DEPTH_DEF  = 16;
  localparam int RF_NUM_RD_DEF = 2;
  localparam int RF_ZERO_REG   = 0;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
// Decodes the read address into the storage array and busy vector, forces the
// zero register (and everything while rst is high) to read 0 / not busy, and,
// when RF_BYPASS_EN is defined, forwards a same-cycle writeback to this port.
// Ports:
//   rst_i      reset (forces zero outputs)
//   addr_i     read address
//   mem_i      storage array from the top level
//   busy_i     scoreboard busy vector
//   wr_en_i / wr_addr_i / wr_data_i   writeback (only with RF_BYPASS_EN)
//   data_o     read data
//   busy_o     addressed register has a pending writeback
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH_DEF,
  parameter int DEPTH = RF_DEPTH_DEF,
  parameter int AW    = $clog2(RF_DEPTH_DEF)
) (
  input  logic             rst_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] mem_i [DEPTH],
  input  logic [DEPTH-1:0] busy_i,
`ifdef RF_BYPASS_EN
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
`endif
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o
);

  always_comb begin
    data_o = mem_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef RF_BYPASS_EN
    // Forwarding the data also forwards the scoreboard clear.
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
      busy_o = 1'b0;
    end
`endif
    // Zero-register force last, so it also overrides a forwarded write to r0.
    if (rst_i || (addr_i == AW'(RF_ZERO_REG))) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: DEPTH x WIDTH register file with NUM_RD combinational
// read ports, one writeback port and a per-register busy scoreboard for RAW
// hazard detection. Register 0 is hardwired zero and never busy.
// Ports:
//   clk, rst (async, active-high)
//   SrcReg / SrcData / SrcBusy : packed read ports, port i at [i*AW +: AW] etc.
//   WriteReg, DstReg, DstData  : writeback (clears busy)
//   IssueEn, IssueReg          : issue (sets busy; wins over a same-cycle clear)
//   BusyCount                  : registered popcount of the busy vector
// Optional feature: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int NUM_RD = RF_NUM_RD_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    SrcReg,
  output logic [NUM_RD*WIDTH-1:0] SrcData,
  output logic [NUM_RD-1:0]       SrcBusy,
  input  logic                    WriteReg,
  input  logic [AW-1:0]           DstReg,
  input  logic [WIDTH-1:0]        DstData,
  input  logic                    IssueEn,
  input  logic [AW-1:0]           IssueReg,
  output logic [AW:0]             BusyCount
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wr_hit, iss_hit, set_evt, clr_evt;

  always_comb begin
    wr_hit  = WriteReg && (DstReg != AW'(RF_ZERO_REG));
    iss_hit = IssueEn && (IssueReg != AW'(RF_ZERO_REG));

    busy_d = busy_q;
    if (wr_hit)  busy_d[DstReg]   = 1'b0;
    if (iss_hit) busy_d[IssueReg] = 1'b1;

    // Count only real transitions so the counter tracks popcount(busy) exactly.
    set_evt = iss_hit && !busy_q[IssueReg];
    clr_evt = wr_hit && busy_q[DstReg] && !(iss_hit && (IssueReg == DstReg));

    cnt_d = cnt_q;
    if (set_evt && !clr_evt)      cnt_d = cnt_q + 1'b1;
    else if (clr_evt && !set_evt) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_hit) mem_q[DstReg] <= DstData;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BusyCount = cnt_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    rf_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_rd (
      .rst_i     (rst),
      .addr_i    (SrcReg[g*AW +: AW]),
      .mem_i     (mem_q),
      .busy_i    (busy_q),
`ifdef RF_BYPASS_EN
      .wr_en_i   (WriteReg),
      .wr_addr_i (DstReg),
      .wr_data_i (DstData),
`endif
      .data_o    (SrcData[g*WIDTH +: WIDTH]),
      .busy_o    (SrcBusy[g])
    );
  end

endmodule
